// File: rtl/gate_ctrl_sched_pkg.sv
// Shared types and widths for the gate-control-list scheduler.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package gate_ctrl_sched_pkg;

  localparam int NUM_Q  = 4;
  localparam int GATE_W = 4;
  localparam int IVL_W  = 24;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [GATE_W-1:0] gate;
    logic [IVL_W-1:0]  interval;
  } gcl_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  localparam gcl_entry_t GCL_RESET = '{gate: 4'hF, interval: 24'd1};

  // A zero interval still occupies one cycle so the list always advances.
  function automatic logic [IVL_W-1:0] slot_len(input logic [IVL_W-1:0] ivl);
    return (ivl == '0) ? IVL_W'(1) : ivl;
  endfunction

endpackage

// File: rtl/gate_ctrl_sched_arb.sv
// Fixed-priority picker: highest set candidate bit wins, result is one-hot.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module gate_prio_arb
  import gate_ctrl_sched_pkg::*;
(
  input  logic [NUM_Q-1:0] cand,
  output logic [NUM_Q-1:0] grant
);

  // Later (higher) indices overwrite earlier ones, so the top set bit wins.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (cand[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_ctrl_sched.sv
// Time-aware gate scheduler: walks a register-based gate control list and grants one open queue at a time.
// Latency: a slot loads the cycle after sched_en rises; a grant registers one cycle after the request is seen.
// Backpressure: a grant is held until pkt_done; define GATE_SCHED_GUARD_EN to block new grants near a slot end.
module gate_ctrl_sched
  import gate_ctrl_sched_pkg::*;
#(
  parameter int GCL_DEPTH    = 8,
  parameter int GUARD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [27:0]       cfg_wdata,
  input  logic [NUM_Q-1:0]  q_req,
  input  logic              pkt_done,
  output logic [NUM_Q-1:0]  q_grant,
  output logic [GATE_W-1:0] gate_state,
  output logic [ADDR_W-1:0] slot_idx,
  output logic              slot_start,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              cfg_err
);

  sched_state_t      state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [ADDR_W-1:0] slot_idx_q, slot_idx_d;
  logic [IVL_W-1:0]  remain_q, remain_d;
  logic              slot_start_q, slot_start_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic [NUM_Q-1:0]  grant_q, grant_d;
  gcl_entry_t        gcl_q [GCL_DEPTH];
  gcl_entry_t        gcl_d [GCL_DEPTH];

  logic              len_ok, last_slot, load, grant_ok;
  logic [ADDR_W-1:0] next_idx, load_idx;
  logic [NUM_Q-1:0]  cand, arb_gnt;

  assign len_ok    = (cfg_len != '0) && (int'(cfg_len) <= GCL_DEPTH);
  assign last_slot = ((int'(slot_idx_q) + 1) >= int'(cfg_len)) || (int'(slot_idx_q) == GCL_DEPTH - 1);
  assign next_idx  = last_slot ? '0 : slot_idx_q + ADDR_W'(1);
  assign cand      = q_req & gate_q;

  gate_prio_arb u_arb (
    .cand  (cand),
    .grant (arb_gnt)
  );

  // Table writes land immediately; out-of-range addresses are dropped.
  always_comb begin
    gcl_d = gcl_q;
    if (cfg_wr && (int'(cfg_addr) < GCL_DEPTH)) gcl_d[cfg_addr] = cfg_wdata;
  end

  // Slot sequencing: IDLE holds gates open, RUN counts down and loads the next entry back to back.
  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    slot_idx_d   = slot_idx_q;
    remain_d     = remain_q;
    slot_start_d = 1'b0;
    cycle_cnt_d  = cycle_cnt_q;
    cfg_err_d    = cfg_err_q | (sched_en & ~len_ok);
    load         = 1'b0;
    load_idx     = '0;
    case (state_q)
      ST_IDLE: begin
        gate_d     = '1;
        slot_idx_d = '0;
        remain_d   = '0;
        if (sched_en && len_ok) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!sched_en) begin
          state_d    = ST_IDLE;
          gate_d     = '1;
          slot_idx_d = '0;
          remain_d   = '0;
        end else if (remain_q <= IVL_W'(1)) begin
          load     = 1'b1;
          load_idx = next_idx;
          if (last_slot) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end else begin
          remain_d = remain_q - IVL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      gate_d       = gcl_q[load_idx].gate;
      remain_d     = slot_len(gcl_q[load_idx].interval);
      slot_idx_d   = load_idx;
      slot_start_d = 1'b1;
    end
  end

  // Grant only from an empty grant register; closing gates never revoke a held grant.
  always_comb begin
`ifdef GATE_SCHED_GUARD_EN
    grant_ok = (state_q != ST_RUN) || (int'(remain_q) > GUARD_CYCLES);
`else
    grant_ok = 1'b1;
`endif
    grant_d = grant_q;
    if (grant_q != '0) begin
      if (pkt_done) grant_d = '0;
    end else if (grant_ok) begin
      grant_d = arb_gnt;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gate_q       <= '1;
      slot_idx_q   <= '0;
      remain_q     <= '0;
      slot_start_q <= 1'b0;
      cycle_cnt_q  <= '0;
      cfg_err_q    <= 1'b0;
      grant_q      <= '0;
      for (int i = 0; i < GCL_DEPTH; i++) gcl_q[i] <= GCL_RESET;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      slot_idx_q   <= slot_idx_d;
      remain_q     <= remain_d;
      slot_start_q <= slot_start_d;
      cycle_cnt_q  <= cycle_cnt_d;
      cfg_err_q    <= cfg_err_d;
      grant_q      <= grant_d;
      gcl_q        <= gcl_d;
    end
  end

  assign q_grant    = grant_q;
  assign gate_state = gate_q;
  assign slot_idx   = slot_idx_q;
  assign slot_start = slot_start_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign cfg_err    = cfg_err_q;

endmodule
